// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types plus the hazard priority decode.
// Latency: pure types and functions, no state.
// Backpressure: n/a.
package cpu_types_pkg;

  localparam int HZD_CNT_W = 16;

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} hzd_state_t;

  typedef struct packed {
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic en_memwb;
    logic fl_ifid;
    logic fl_idex;
    logic fl_exmem;
    logic pc_en;
    logic redir_ex;
    logic redir_mem;
  } hzd_ctl_t;

  // Priority decode once the D-cache is not holding the pipe; older stages win.
  function automatic hzd_ctl_t hzd_rules(input logic halt, input logic mispredict,
                                         input logic jump, input logic lduse,
                                         input logic ihit);
    hzd_ctl_t c;
    c = '0;
    if (halt) begin
      c.fl_ifid  = 1'b1;
      c.fl_idex  = 1'b1;
      c.fl_exmem = 1'b1;
      c.en_memwb = 1'b1;
    end else if (mispredict) begin
      c.fl_ifid   = 1'b1;
      c.fl_idex   = 1'b1;
      c.fl_exmem  = 1'b1;
      c.en_memwb  = 1'b1;
      c.redir_mem = 1'b1;
      c.pc_en     = 1'b1;
    end else if (jump) begin
      c.fl_ifid  = 1'b1;
      c.fl_idex  = 1'b1;
      c.en_exmem = 1'b1;
      c.en_memwb = 1'b1;
      c.redir_ex = 1'b1;
      c.pc_en    = 1'b1;
    end else if (lduse) begin
      c.fl_idex  = 1'b1;
      c.en_exmem = 1'b1;
      c.en_memwb = 1'b1;
    end else if (!ihit) begin
      c.fl_ifid  = 1'b1;
      c.en_idex  = 1'b1;
      c.en_exmem = 1'b1;
      c.en_memwb = 1'b1;
    end else begin
      c.en_ifid  = 1'b1;
      c.en_idex  = 1'b1;
      c.en_exmem = 1'b1;
      c.en_memwb = 1'b1;
      c.pc_en    = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects inc one cycle later.
// Backpressure: none; inc is ignored once saturated.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline latch/PC sequencer: stalls, bubbles and redirects from hazards and cache handshakes.
// Latency: strobes are combinational from state and inputs; state/counters update on CLK.
// Backpressure: a pending D-cache access freezes every latch and the PC until dhit.
module hazard_controller
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = HZD_CNT_W,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_mem,
  input  logic             dREN_ex,
  input  logic [REG_W-1:0] Rt_ex,
  input  logic [REG_W-1:0] Rs_id,
  input  logic [REG_W-1:0] Rt_id,
  input  logic             jump_ex,
  input  logic             mispredict_mem,
  input  logic             halt_mem,
  output logic             enable_ifid,
  output logic             enable_idex,
  output logic             enable_exmem,
  output logic             enable_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             pc_en,
  output logic             redirect_ex,
  output logic             redirect_mem,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  hzd_state_t state;
  hzd_ctl_t   ctl;
  logic       lduse;
  logic       stall_inc;
  logic       flush_inc;

  assign lduse = dREN_ex && (Rt_ex != '0) && ((Rt_ex == Rs_id) || (Rt_ex == Rt_id));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (dmem_req_mem && !dhit) state <= DWAIT;
          else if (halt_mem)         state <= DRAIN;
        end
        DWAIT:   if (dhit) state <= halt_mem ? DRAIN : RUN;
        DRAIN:   state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  // A mispredict seen while waiting on the D-cache is only honoured in the dhit cycle.
  always_comb begin
    ctl = '0;
    case (state)
      RUN:     if (!(dmem_req_mem && !dhit)) ctl = hzd_rules(halt_mem, mispredict_mem, jump_ex, lduse, ihit);
      DWAIT:   if (dhit) ctl = hzd_rules(halt_mem, mispredict_mem, jump_ex, lduse, ihit);
      default: ctl = '0;
    endcase
    if (!nRST) ctl = '0;
  end

  assign enable_ifid  = ctl.en_ifid;
  assign enable_idex  = ctl.en_idex;
  assign enable_exmem = ctl.en_exmem;
  assign enable_memwb = ctl.en_memwb;
  assign flush_ifid   = ctl.fl_ifid;
  assign flush_idex   = ctl.fl_idex;
  assign flush_exmem  = ctl.fl_exmem;
  assign pc_en        = ctl.pc_en;
  assign redirect_ex  = ctl.redir_ex;
  assign redirect_mem = ctl.redir_mem;
  assign halted       = (state == HALTED);

  assign stall_inc = nRST && ((state == RUN) || (state == DWAIT)) && !ctl.pc_en;
  assign flush_inc = ctl.redir_ex || ctl.redir_mem;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: per-cycle reference model plus hand-computed spot checks.
module tb_hazard_controller;

  localparam int CNT_W = 16;
  localparam int REG_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // Strobe patterns: {en_ifid,en_idex,en_exmem,en_memwb, fl_ifid,fl_idex,fl_exmem, pc_en, redir_ex,redir_mem}
  localparam logic [9:0] P_HOLD  = 10'b0000_000_0_00;
  localparam logic [9:0] P_HALT  = 10'b0001_111_0_00;
  localparam logic [9:0] P_MISP  = 10'b0001_111_1_01;
  localparam logic [9:0] P_JUMP  = 10'b0011_110_1_10;
  localparam logic [9:0] P_LDUSE = 10'b0011_010_0_00;
  localparam logic [9:0] P_NOIF  = 10'b0111_100_0_00;
  localparam logic [9:0] P_GO    = 10'b1111_000_1_00;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit, dhit, dmem_req_mem, dREN_ex, jump_ex, mispredict_mem, halt_mem;
  logic [REG_W-1:0] Rt_ex, Rs_id, Rt_id;
  logic enable_ifid, enable_idex, enable_exmem, enable_memwb;
  logic flush_ifid, flush_idex, flush_exmem;
  logic pc_en, redirect_ex, redirect_mem, halted;
  logic [CNT_W-1:0] stall_count, flush_count;

  int vectors = 0;
  int miscompares = 0;

  // Model: 0 = running, 1 = waiting on D-cache, 2 = draining halt, 3 = stopped
  int phase = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 CLK = ~CLK;

  hazard_controller #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req_mem(dmem_req_mem),
    .dREN_ex(dREN_ex), .Rt_ex(Rt_ex), .Rs_id(Rs_id), .Rt_id(Rt_id),
    .jump_ex(jump_ex), .mispredict_mem(mispredict_mem), .halt_mem(halt_mem),
    .enable_ifid(enable_ifid), .enable_idex(enable_idex), .enable_exmem(enable_exmem),
    .enable_memwb(enable_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .pc_en(pc_en), .redirect_ex(redirect_ex),
    .redirect_mem(redirect_mem), .halted(halted), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  function automatic logic [9:0] expect_ctl();
    logic lu;
    lu = dREN_ex && (Rt_ex != 0) && ((Rt_ex == Rs_id) || (Rt_ex == Rt_id));
    if (phase >= 2) return P_HOLD;
    if ((phase == 0) ? (dmem_req_mem && !dhit) : !dhit) return P_HOLD;
    if (halt_mem)       return P_HALT;
    if (mispredict_mem) return P_MISP;
    if (jump_ex)        return P_JUMP;
    if (lu)             return P_LDUSE;
    if (!ihit)          return P_NOIF;
    return P_GO;
  endfunction

  task automatic model_check();
    logic [9:0]  e;
    logic [42:0] act, exp;
    if (!nRST) begin
      phase = 0; m_stall = 0; m_flush = 0;
      e = P_HOLD;
    end else begin
      e = expect_ctl();
    end
    act = {enable_ifid, enable_idex, enable_exmem, enable_memwb, flush_ifid, flush_idex,
           flush_exmem, pc_en, redirect_ex, redirect_mem, halted, stall_count, flush_count};
    exp = {e, (phase == 3), m_stall[15:0], m_flush[15:0]};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL model_cycle t=%0t got %h want %h", $time, act, exp);
    end
    if (nRST) begin
      if (phase <= 1 && !e[2] && m_stall < CMAX) m_stall++;
      if ((e[1] || e[0]) && m_flush < CMAX) m_flush++;
      if (phase == 3)          phase = 3;
      else if (phase == 2)     phase = 3;
      else if (e == P_HOLD)    phase = 1;
      else if (halt_mem)       phase = 2;
      else                     phase = 0;
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic neg();
    @(negedge CLK);
    model_check();
  endtask

  task automatic pos();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      neg();
      pos();
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; dmem_req_mem = 1'b0; dREN_ex = 1'b0;
    Rt_ex = '0; Rs_id = '0; Rt_id = '0;
    jump_ex = 1'b0; mispredict_mem = 1'b0; halt_mem = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    step(2);
    nRST = 1'b1;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    neg();
    check_lit("reset_strobes", {enable_ifid, enable_idex, enable_exmem, enable_memwb, pc_en, halted}, 0);
    check_lit("reset_counts", {stall_count, flush_count}, 0);
    pos();
    nRST = 1'b1;

    for (int i = 0; i < 10; i++) begin
      neg();
      check_lit("idle_go", {enable_ifid, enable_idex, enable_exmem, enable_memwb, pc_en}, 5'h1F);
      pos();
    end
    neg();
    check_lit("idle_stall_cnt", stall_count, 0);
    pos();

    // lw $5 in ID/EX feeding add in IF/ID
    dREN_ex = 1'b1; Rt_ex = 5'd5; Rs_id = 5'd5; Rt_id = 5'd3;
    neg();
    check_lit("lduse_strobes", {enable_ifid, flush_idex, pc_en}, 3'b010);
    pos();
    idle();
    neg();
    check_lit("lduse_stall_cnt", stall_count, 1);
    pos();

    dREN_ex = 1'b1; Rt_ex = 5'd0; Rs_id = 5'd0; Rt_id = 5'd0;
    neg();
    check_lit("lduse_r0_pc_en", pc_en, 1);
    pos();
    idle();
    neg();
    check_lit("lduse_r0_stall_cnt", stall_count, 1);
    pos();

    do_reset();
    dmem_req_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      neg();
      check_lit("dwait_frozen", {enable_ifid, enable_idex, enable_exmem, enable_memwb, pc_en}, 0);
      pos();
    end
    dhit = 1'b1;
    neg();
    check_lit("dwait_resume", {enable_ifid, enable_idex, enable_exmem, enable_memwb, pc_en}, 5'h1F);
    pos();
    idle();
    neg();
    check_lit("dwait_stall_cnt", stall_count, 3);
    pos();

    do_reset();
    mispredict_mem = 1'b1; jump_ex = 1'b1;
    neg();
    check_lit("misp_over_jump", {redirect_mem, redirect_ex, flush_ifid, flush_idex, flush_exmem}, 5'b10111);
    pos();
    idle();
    neg();
    check_lit("misp_flush_cnt", flush_count, 1);
    pos();

    // jump with a missing fetch and a load-use behind it: redirect still wins
    jump_ex = 1'b1; ihit = 1'b0; dREN_ex = 1'b1; Rt_ex = 5'd7; Rt_id = 5'd7;
    neg();
    check_lit("jump_noihit", {pc_en, flush_ifid, flush_idex, enable_ifid, redirect_ex}, 5'b11101);
    pos();
    idle();
    neg();
    check_lit("jump_flush_cnt", flush_count, 2);
    pos();

    do_reset();
    dmem_req_mem = 1'b1; mispredict_mem = 1'b1;
    for (int i = 0; i < 2; i++) begin
      neg();
      check_lit("dwait_misp_held", {redirect_mem, pc_en}, 0);
      pos();
    end
    dhit = 1'b1;
    neg();
    check_lit("dwait_misp_dhit", {redirect_mem, pc_en, flush_ifid, flush_idex, flush_exmem}, 5'h1F);
    pos();
    idle();
    neg();
    check_lit("dwait_misp_cnts", {stall_count, flush_count}, {16'd2, 16'd1});
    pos();

    do_reset();
    halt_mem = 1'b1;
    neg();
    check_lit("halt_strobes", {flush_ifid, flush_idex, flush_exmem, enable_memwb, pc_en}, 5'b11110);
    pos();
    idle();
    neg();
    check_lit("drain_quiet", {enable_ifid, enable_idex, enable_exmem, enable_memwb,
                              flush_ifid, flush_idex, flush_exmem, pc_en, halted}, 0);
    pos();
    for (int i = 0; i < 20; i++) begin
      neg();
      check_lit("halted_hold", {halted, pc_en, enable_ifid, enable_memwb}, 4'b1000);
      pos();
    end
    neg();
    check_lit("halted_stall_cnt", stall_count, 1);
    pos();
    nRST = 1'b0;
    step(1);
    nRST = 1'b1;
    neg();
    check_lit("halt_exit_reset", {halted, pc_en, stall_count, flush_count}, {2'b01, 32'd0});
    pos();

    // reset while parked in DWAIT leaves nothing pending
    dmem_req_mem = 1'b1;
    step(2);
    nRST = 1'b0;
    step(1);
    nRST = 1'b1;
    dhit = 1'b1;
    neg();
    check_lit("dwait_reset", {pc_en, stall_count}, {1'b1, 16'd0});
    pos();

    do_reset();
    idle();
    ihit = 1'b0;
    step(CMAX + 6);
    ihit = 1'b1;
    neg();
    check_lit("stall_saturate", stall_count, 16'hFFFF);
    pos();
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
